// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX and RX sides.
//   uart_state_e   frame FSM states (PARITY only reachable when parity is built in)
//   UART_*_LVL     line levels for idle, start and stop bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// uart_tx_fifo_reader_if: read-side link between the TX FIFO (memory + writer) and
// the reader.
//   wr_ptr    writer pointer, MSB is the wrap bit    (FIFO side -> reader)
//   fifo_data fifo_mem data_out at rd_addr           (FIFO side -> reader)
//   rd_addr   fifo_mem read address                  (reader -> FIFO side)
//   rd_ptr    reader pointer, used for full detection (reader -> FIFO side)
//   empty     wr_ptr == rd_ptr                       (reader -> FIFO side)
// modport master = reader, modport slave = FIFO memory / writer.
interface uart_tx_fifo_reader_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_C_WIDTH = 4
);
    logic [FIFO_C_WIDTH:0]   wr_ptr;
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic [FIFO_C_WIDTH-1:0] rd_addr;
    logic [FIFO_C_WIDTH:0]   rd_ptr;
    logic                    empty;

    modport master (
        input  wr_ptr,
        input  fifo_data,
        output rd_addr,
        output rd_ptr,
        output empty
    );

    modport slave (
        output wr_ptr,
        output fifo_data,
        input  rd_addr,
        input  rd_ptr,
        input  empty
    );
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..CLKS_PER_BIT-1 and wraps; bit_done marks the
// last cycle of each bit period.
//   clk      system clock
//   rst_n    synchronous active-low reset
//   clr_i    hold the count at 0
//   bit_done_o high on the final cycle of a bit period
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic bit_done_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_done_o = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: read side of the TX byte FIFO. Owns the read pointer,
// pops a byte whenever the FIFO is non-empty and sends it as a UART frame
// (start, DATA_WIDTH data bits LSB first, optional even parity, stop).
//   clk, rst_n   system clock, synchronous active-low reset
//   fifo         uart_tx_fifo_reader_if.master (wr_ptr, fifo_data in;
//                rd_addr, rd_ptr, empty out)
//   tx           serial line, idle high, driven from a flop
//   tx_busy      high from pop until the end of the last stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_C_WIDTH = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_tx_fifo_reader_if.master  fifo,
    output logic                   tx,
    output logic                   tx_busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [FIFO_C_WIDTH:0] PTR_ONE = {{FIFO_C_WIDTH{1'b0}}, 1'b1};

    uart_state_e             state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [FIFO_C_WIDTH:0]   rd_ptr_q;
    logic [BW-1:0]           bit_q;
    logic                    tx_q;
    logic                    busy_q;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    logic empty;
    logic bit_done;
    logic pop;

    assign empty        = (fifo.wr_ptr == rd_ptr_q);
    assign fifo.empty   = empty;
    assign fifo.rd_ptr  = rd_ptr_q;
    assign fifo.rd_addr = rd_ptr_q[FIFO_C_WIDTH-1:0];
    assign tx           = tx_q;
    assign tx_busy      = busy_q;

    // Every state change lands on a bit boundary where the counter wraps to 0
    // anyway, so holding it clear in IDLE is all that is needed for each new
    // state to start at count 0.
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == IDLE),
        .bit_done_o (bit_done)
    );

    // Pop from IDLE, or on the last stop-bit cycle for back-to-back frames.
    assign pop = !empty && ((state_q == IDLE) || (state_q == STOP && bit_done));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            rd_ptr_q <= '0;
            bit_q    <= '0;
            tx_q     <= UART_IDLE_LVL;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (pop) begin
            shift_q  <= fifo.fifo_data;
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            busy_q   <= 1'b1;
            state_q  <= START;
            tx_q     <= UART_START_LVL;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo.fifo_data;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= UART_IDLE_LVL;
                end
                START: begin
                    if (bit_done) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= UART_STOP_LVL;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            tx_q  <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state_q <= STOP;
                        tx_q    <= UART_STOP_LVL;
                    end
                end
`endif
                STOP: begin
                    // Non-empty case was taken by pop above.
                    if (bit_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= UART_IDLE_LVL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LVL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
module tb_uart_tx_fifo_reader;
    localparam int DW  = 8;
    localparam int FCW = 4;
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, tx_busy;

    uart_tx_fifo_reader_if #(.DATA_WIDTH(DW), .FIFO_C_WIDTH(FCW)) fif ();

    logic [DW-1:0] mem [2**FCW];
    assign fif.fifo_data = mem[fif.rd_addr];

    uart_tx_fifo_reader #(.DATA_WIDTH(DW), .FIFO_C_WIDTH(FCW), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo    (fif.master),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_q[$];
    int starts_q[$];
    int frames_seen = 0;
    bit mon_en = 0;
    bit saw_full = 0, saw_wrap = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Line monitor: finds a start bit, samples each bit at mid-period and
    // compares the decoded frame with the scoreboard.
    bit m_act = 0;
    int m_cnt = 0;
    logic [NBITS-1:0] m_bits;
    logic [DW-1:0] m_byte, m_exp;
    always @(negedge clk) begin
        if (!mon_en) begin
            m_act = 0;
        end else begin
            if (!m_act && tx == 1'b0) begin
                m_act = 1;
                m_cnt = 0;
                starts_q.push_back(cyc);
            end
            if (m_act) begin
                if (m_cnt % CPB == CPB / 2) m_bits[m_cnt / CPB] = tx;
                if (m_cnt == (NBITS - 1) * CPB + CPB / 2) begin
                    m_act  = 0;
                    m_byte = m_bits[DW:1];
                    frames_seen++;
                    chk("start_bit", m_bits[0], 0);
                    chk("stop_bit", m_bits[NBITS-1], 1);
                    chk("busy_in_frame", tx_busy, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", m_byte, 9'h100);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("data_byte", m_byte, m_exp);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", m_bits[DW+1], ^m_exp);
`endif
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Read pointer must only ever step by one, wrapping mod 2**(FCW+1).
    logic [FCW:0] prev_rd = '0;
    always @(negedge clk) begin
        if (mon_en && fif.rd_ptr != prev_rd) begin
            chk("rd_ptr_step", fif.rd_ptr, (prev_rd + 1) % (2**(FCW+1)));
            if (prev_rd == 5'd31 && fif.rd_ptr == 5'd0) saw_wrap = 1;
        end
        prev_rd = fif.rd_ptr;
    end

    task automatic write_byte(input logic [DW-1:0] b);
        int w;
        logic full;
        w = 0;
        @(negedge clk);
        full = (fif.wr_ptr[FCW] != fif.rd_ptr[FCW]) && (fif.wr_ptr[FCW-1:0] == fif.rd_ptr[FCW-1:0]);
        while (full && w < 5000) begin
            if (!saw_full) begin
                saw_full = 1;
                chk("empty_when_full", fif.empty, 0);
            end
            @(negedge clk);
            w++;
            full = (fif.wr_ptr[FCW] != fif.rd_ptr[FCW]) && (fif.wr_ptr[FCW-1:0] == fif.rd_ptr[FCW-1:0]);
        end
        if (w >= 5000) chk("write_timeout", w, 0);
        mem[fif.wr_ptr[FCW-1:0]] = b;
        fif.wr_ptr = fif.wr_ptr + 1'b1;
        exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || !fif.empty || m_act) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("idle_timeout", n, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, wait_n;
        fif.wr_ptr = '0;
        for (int i = 0; i < 2**FCW; i++) mem[i] = '0;

        // Reset
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rd_ptr", fif.rd_ptr, 0);
        chk("rst_empty", fif.empty, 1);
        prev_rd = fif.rd_ptr;
        mon_en = 1;
        f0 = frames_seen;
        repeat (1000) @(negedge clk);
        chk("no_frame_when_empty", frames_seen - f0 + starts_q.size(), 0);
        chk("idle_tx", tx, 1);

        // Single byte 0xA5
        write_byte(8'hA5);
        @(posedge clk); #1;
        chk("pop_rd_ptr", fif.rd_ptr, 1);
        chk("pop_tx_low", tx, 0);
        chk("pop_busy", tx_busy, 1);
        n = 0;
        while (tx_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_length", n, FRAME);
        wait_idle();
        chk("single_frames", frames_seen, 1);

        // Burst: three contiguous frames
        starts_q.delete();
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h55);
        wait_n = 0;
        while (fif.rd_ptr != 5'd4 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        chk("burst_third_pop", fif.rd_ptr, 4);
        chk("burst_empty", fif.empty, 1);
        wait_idle();
        chk("burst_frames", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            chk("burst_gap1", starts_q[1] - starts_q[0], FRAME);
            chk("burst_gap2", starts_q[2] - starts_q[1], FRAME);
        end

        // Parity-pattern bytes
        write_byte(8'h07);
        wait_idle();
        write_byte(8'h03);
        wait_idle();

        // Wrap: 40 random bytes, writer stalls on full
        for (int i = 0; i < 40; i++) write_byte(8'($urandom_range(0, 255)));
        wait_idle();
        chk("saw_full", saw_full, 1);
        chk("saw_wrap", saw_wrap, 1);
        chk("wrap_rd_ptr", fif.rd_ptr, (6 + 40) % 32);

        // Reset mid-frame during data bit 3
        write_byte(8'h00);
        wait_n = 0;
        while (!tx_busy && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (CPB + 3 * CPB + 5) @(negedge clk);
        chk("mid_tx_low", tx, 0);
        mon_en = 0;
        exp_q.delete();
        rst_n = 0;
        fif.wr_ptr = '0;
        @(posedge clk); #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_rd_ptr", fif.rd_ptr, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_empty", fif.empty, 1);
        @(negedge clk);
        rst_n = 1;
        prev_rd = fif.rd_ptr;
        mon_en = 1;
        f0 = frames_seen;
        write_byte(8'h3C);
        wait_idle();
        chk("after_reset_frame", frames_seen - f0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
